// File: rtl/tlp_eth_framer.sv
// tlp_eth_framer: pops captured PCIe TLPs from a first-word-fall-through FIFO and emits each one
// as an Ethernet/IPv4/UDP/NetTLP frame on a 64-bit AXI-stream toward the 10G MAC.
//
// Ports:
//   eth_clk, eth_rst            clock, synchronous active-high reset
//   fifo_tdata/tkeep/tlast      FWFT head entry (byte n at bits [8n+7:8n])
//   fifo_len, fifo_tag          TLP byte length and tag, valid on the first beat only
//   fifo_empty, fifo_rd_en      FIFO status / pop strobe
//   cfg_*_mac, cfg_*_ip         addressing, sampled when a frame starts
//   m_tdata/tkeep/tlast/tvalid  frame stream, m_tready from the MAC
//   pkt_cnt, drop_cnt, err_len_cnt  frames sent, entries dropped, length mismatches
module tlp_eth_framer #(
  parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
  parameter logic [7:0]  IP_TTL        = 8'd64,
  parameter logic [11:0] MAX_TLP_LEN   = 12'd528
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic [63:0] fifo_tdata,
  input  logic [7:0]  fifo_tkeep,
  input  logic        fifo_tlast,
  input  logic [11:0] fifo_len,
  input  logic [7:0]  fifo_tag,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [47:0] cfg_src_mac,
  input  logic [47:0] cfg_dst_mac,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_len_cnt
);

  typedef enum logic [2:0] {StIdle, StDrop, StCsum1, StCsum2, StHdr, StPayload} state_e;

  state_e      state_q, state_d;
  logic [2:0]  beat_q;
  logic [11:0] len_q;
  logic [3:0]  tag_q;
  logic [47:0] src_mac_q, dst_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [31:0] tstamp_q, tstamp_lat_q;
  logic [15:0] seq_q;
  logic [19:0] csum_acc_q;
  logic [15:0] csum_q;
  logic [15:0] byte_acc_q;
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q, err_len_cnt_q;

  // Only the low tag nibble selects the UDP port.
  logic unused_tag;
  assign unused_tag = ^fifo_tag[7:4];

  logic [15:0] total_len, udp_len, udp_port;
  assign total_len = 16'd34 + {4'b0, len_q};
  assign udp_len   = 16'd14 + {4'b0, len_q};
  assign udp_port  = UDP_PORT_BASE + {12'b0, tag_q};

  logic [19:0] csum_sum;
  assign csum_sum = 20'h04500 + {4'b0, total_len} + {4'b0, seq_q} + 20'h04000
                  + {4'b0, IP_TTL, 8'h11} + {4'b0, src_ip_q[31:16]} + {4'b0, src_ip_q[15:0]}
                  + {4'b0, dst_ip_q[31:16]} + {4'b0, dst_ip_q[15:0]};

  // Two folds: the second cannot carry again.
  logic [16:0] fold1;
  logic [15:0] fold2;
  assign fold1 = {1'b0, csum_acc_q[15:0]} + {13'b0, csum_acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  // Header in wire order, wire byte 0 in the top byte.
  logic [383:0] hdr_be;
  assign hdr_be = {dst_mac_q, src_mac_q, 16'h0800,
                   8'h45, 8'h00, total_len, seq_q, 16'h4000, IP_TTL, 8'h11, csum_q,
                   src_ip_q, dst_ip_q,
                   udp_port, udp_port, udp_len, 16'h0000,
                   seq_q, tstamp_lat_q};

  logic [63:0] hdr_beat [6];
  always_comb begin
    for (int b = 0; b < 6; b++) begin
      hdr_beat[b] = '0;
      for (int n = 0; n < 8; n++) begin
        hdr_beat[b][8*n +: 8] = hdr_be[383 - 8*(8*b + n) -: 8];
      end
    end
  end

  logic [3:0] keep_cnt;
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + {3'b0, fifo_tkeep[i]};
  end

  logic len_bad;
  assign len_bad = (fifo_len == 12'd0) || (fifo_len > MAX_TLP_LEN);

  always_comb begin
    state_d    = state_q;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tkeep    = '0;
    m_tlast    = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = len_bad ? StDrop : StCsum1;
      end
      StDrop: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty && fifo_tlast) state_d = StIdle;
      end
      StCsum1: state_d = StCsum2;
      StCsum2: state_d = StHdr;
      StHdr: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_beat[beat_q];
        m_tkeep  = 8'hFF;
        if (m_tready && beat_q == 3'd5) state_d = StPayload;
      end
      StPayload: begin
        m_tvalid   = !fifo_empty;
        m_tdata    = fifo_tdata;
        m_tkeep    = fifo_tkeep;
        m_tlast    = fifo_tlast;
        fifo_rd_en = !fifo_empty && m_tready;
        if (!fifo_empty && m_tready && fifo_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      len_q         <= '0;
      tag_q         <= '0;
      src_mac_q     <= '0;
      dst_mac_q     <= '0;
      src_ip_q      <= '0;
      dst_ip_q      <= '0;
      tstamp_q      <= '0;
      tstamp_lat_q  <= '0;
      seq_q         <= '0;
      csum_acc_q    <= '0;
      csum_q        <= '0;
      byte_acc_q    <= '0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      err_len_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tstamp_q <= tstamp_q + 32'd1;
      case (state_q)
        StIdle: begin
          beat_q     <= '0;
          byte_acc_q <= '0;
          if (state_d == StCsum1) begin
            len_q        <= fifo_len;
            tag_q        <= fifo_tag[3:0];
            src_mac_q    <= cfg_src_mac;
            dst_mac_q    <= cfg_dst_mac;
            src_ip_q     <= cfg_src_ip;
            dst_ip_q     <= cfg_dst_ip;
            tstamp_lat_q <= tstamp_q;
          end
        end
        StDrop: begin
          if (fifo_rd_en && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
        StCsum1: csum_acc_q <= csum_sum;
        StCsum2: csum_q <= ~fold2;
        StHdr: begin
          if (m_tready) beat_q <= beat_q + 3'd1;
        end
        StPayload: begin
          if (fifo_rd_en) begin
            byte_acc_q <= byte_acc_q + {12'b0, keep_cnt};
            if (fifo_tlast) begin
              pkt_cnt_q <= pkt_cnt_q + 32'd1;
              seq_q     <= seq_q + 16'd1;
              if ((byte_acc_q + {12'b0, keep_cnt}) != {4'b0, len_q} &&
                  err_len_cnt_q != 16'hFFFF) begin
                err_len_cnt_q <= err_len_cnt_q + 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pkt_cnt     = pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_len_cnt = err_len_cnt_q;

endmodule

// File: tb/tb_tlp_eth_framer.sv
// Directed bench for tlp_eth_framer: a queue-backed FWFT FIFO model feeds TLPs, frames are
// collected byte-wise from the stream and header fields are compared with hand-computed values.
module tb_tlp_eth_framer;

  logic        eth_clk = 1'b0;
  logic        eth_rst;
  logic [63:0] fifo_tdata;
  logic [7:0]  fifo_tkeep;
  logic        fifo_tlast;
  logic [11:0] fifo_len;
  logic [7:0]  fifo_tag;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [47:0] cfg_src_mac, cfg_dst_mac;
  logic [31:0] cfg_src_ip, cfg_dst_ip;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt, err_len_cnt;

  tlp_eth_framer dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst),
    .fifo_tdata(fifo_tdata), .fifo_tkeep(fifo_tkeep), .fifo_tlast(fifo_tlast),
    .fifo_len(fifo_len), .fifo_tag(fifo_tag), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .cfg_src_mac(cfg_src_mac), .cfg_dst_mac(cfg_dst_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_len_cnt(err_len_cnt)
  );

  always #5 eth_clk = ~eth_clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [11:0] len;
    logic [7:0]  tag;
    int          gap;
  } ent_t;

  ent_t        fq[$];
  logic [7:0]  exp_pl[$];
  logic [7:0]  frm[$];
  int          gap_left = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc;

  // Reference tstamp: free-running cycle count since reset.
  always @(posedge eth_clk) begin
    if (eth_rst) cyc <= '0;
    else         cyc <= cyc + 32'd1;
  end

  task automatic drive_head();
    if (fq.size() == 0 || gap_left > 0) begin
      fifo_empty = 1'b1;
      fifo_tdata = '0;
      fifo_tkeep = '0;
      fifo_tlast = 1'b0;
      fifo_len   = '0;
      fifo_tag   = '0;
    end else begin
      fifo_empty = 1'b0;
      fifo_tdata = fq[0].data;
      fifo_tkeep = fq[0].keep;
      fifo_tlast = fq[0].last;
      fifo_len   = fq[0].len;
      fifo_tag   = fq[0].tag;
    end
  endtask

  // FWFT FIFO model: pop on a sampled rd_en, update the head just after the edge.
  always @(posedge eth_clk) begin
    bit pop;
    pop = fifo_rd_en && !fifo_empty;
    #1;
    if (eth_rst) begin
      fq.delete();
      gap_left = 0;
    end else begin
      if (gap_left > 0) gap_left--;
      if (pop) begin
        void'(fq.pop_front());
        if (fq.size() > 0 && fq[0].gap > 0) gap_left = fq[0].gap;
      end
    end
    drive_head();
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] seed, input logic [7:0] keep, input logic last,
                      input logic [11:0] len, input logic [7:0] tag, input int gap,
                      input bit in_frame);
    ent_t e;
    for (int n = 0; n < 8; n++) e.data[8*n +: 8] = seed + 8'(n);
    e.keep = keep;
    e.last = last;
    e.len  = len;
    e.tag  = tag;
    e.gap  = gap;
    fq.push_back(e);
    if (in_frame) begin
      for (int n = 0; n < 8; n++) if (keep[n]) exp_pl.push_back(e.data[8*n +: 8]);
    end
  endtask

  int          beats, gaps, stall_viol;
  logic [7:0]  last_keep;
  logic [31:0] t_first;

  // rdy_mode 0: always ready; 1: ready toggles every cycle.
  task automatic run_frame(input int rdy_mode);
    bit started = 0;
    bit done = 0;
    bit hold = 0;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    frm.delete();
    beats = 0;
    gaps = 0;
    stall_viol = 0;
    last_keep = '0;
    t_first = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge eth_clk);
      m_tready = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 1);
      #1;
      if (hold && (!m_tvalid || m_tdata !== hd || m_tkeep !== hk || m_tlast !== hl))
        stall_viol++;
      hold = 0;
      if (m_tvalid) begin
        if (!started) begin
          started = 1;
          t_first = cyc;
        end
        if (m_tready) begin
          beats++;
          for (int n = 0; n < 8; n++) if (m_tkeep[n]) frm.push_back(m_tdata[8*n +: 8]);
          last_keep = m_tkeep;
          if (m_tlast) done = 1;
        end else begin
          hold = 1;
          hd = m_tdata;
          hk = m_tkeep;
          hl = m_tlast;
        end
      end else if (started) begin
        gaps++;
      end
    end
    check_val("frame_done", 64'(done), 64'd1);
    @(negedge eth_clk);
  endtask

  function automatic logic [15:0] get16(input int k);
    return {frm[k], frm[k+1]};
  endfunction

  function automatic logic [31:0] get32(input int k);
    return {frm[k], frm[k+1], frm[k+2], frm[k+3]};
  endfunction

  task automatic check_frame(input string tn, input int exp_bytes, input int exp_beats,
                             input logic [7:0] exp_lkeep, input logic [15:0] tot,
                             input logic [15:0] seq, input logic [15:0] csum,
                             input logic [15:0] port, input logic [15:0] ulen,
                             input int exp_gaps);
    int bad = 0;
    check_val({tn, "/bytes"}, 64'(frm.size()), 64'(exp_bytes));
    check_val({tn, "/beats"}, 64'(beats), 64'(exp_beats));
    check_val({tn, "/last_keep"}, 64'(last_keep), 64'(exp_lkeep));
    check_val({tn, "/gaps"}, 64'(gaps), 64'(exp_gaps));
    check_val({tn, "/stable"}, 64'(stall_viol), 64'd0);
    if (frm.size() >= 48) begin
      check_val({tn, "/dst_mac"}, {get16(0), get32(2)}, cfg_dst_mac);
      check_val({tn, "/src_mac"}, {get16(6), get32(8)}, cfg_src_mac);
      check_val({tn, "/ethertype"}, get16(12), 16'h0800);
      check_val({tn, "/ver_tos"}, get16(14), 16'h4500);
      check_val({tn, "/ip_len"}, get16(16), tot);
      check_val({tn, "/ip_id"}, get16(18), seq);
      check_val({tn, "/frag"}, get16(20), 16'h4000);
      check_val({tn, "/ttl_proto"}, get16(22), 16'h4011);
      check_val({tn, "/ip_csum"}, get16(24), csum);
      check_val({tn, "/src_ip"}, get32(26), cfg_src_ip);
      check_val({tn, "/dst_ip"}, get32(30), cfg_dst_ip);
      check_val({tn, "/udp_sport"}, get16(34), port);
      check_val({tn, "/udp_dport"}, get16(36), port);
      check_val({tn, "/udp_len"}, get16(38), ulen);
      check_val({tn, "/udp_csum"}, get16(40), 16'h0000);
      check_val({tn, "/nettlp_seq"}, get16(42), seq);
      check_val({tn, "/tstamp"}, get32(44), t_first - 32'd3);
      for (int i = 0; i < exp_pl.size(); i++) begin
        if (48 + i >= frm.size()) bad++;
        else if (frm[48+i] !== exp_pl[i]) bad++;
      end
      check_val({tn, "/payload"}, 64'(bad), 64'd0);
    end
    exp_pl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs;
    bit hit;
    cfg_dst_mac = 48'h02_00_00_00_00_02;
    cfg_src_mac = 48'h02_00_00_00_00_01;
    cfg_src_ip  = 32'h0A00_0001;
    cfg_dst_ip  = 32'h0A00_0002;
    m_tready    = 1'b0;
    eth_rst     = 1'b1;
    repeat (3) @(negedge eth_clk);
    check_val("rst/tvalid", 64'(m_tvalid), 64'd0);
    check_val("rst/tdata", m_tdata, 64'd0);
    check_val("rst/tkeep", 64'(m_tkeep), 64'd0);
    check_val("rst/tlast", 64'(m_tlast), 64'd0);
    check_val("rst/rd_en", 64'(fifo_rd_en), 64'd0);
    check_val("rst/pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_val("rst/drop_cnt", 64'(drop_cnt), 64'd0);
    check_val("rst/err_len_cnt", 64'(err_len_cnt), 64'd0);
    eth_rst = 1'b0;
    repeat (2) @(negedge eth_clk);

    // T1: 3DW MRd, len 12, tag 05
    push(8'h10, 8'hFF, 1'b0, 12'd12, 8'h05, 0, 1'b1);
    push(8'h20, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(0);
    check_frame("mrd", 60, 8, 8'h0F, 16'h002E, 16'h0000, 16'h26BD, 16'h3005, 16'h001A, 0);
    check_val("mrd/pkt_cnt", 64'(pkt_cnt), 64'd1);

    // T2: MWr len 28, tag 17 (port uses tag[3:0]), ready toggling
    push(8'h30, 8'hFF, 1'b0, 12'd28, 8'h17, 0, 1'b1);
    push(8'h40, 8'hFF, 1'b0, 12'd0, 8'h00, 0, 1'b1);
    push(8'h50, 8'hFF, 1'b0, 12'd0, 8'h00, 0, 1'b1);
    push(8'h60, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(1);
    check_frame("mwr", 76, 10, 8'h0F, 16'h003E, 16'h0001, 16'h26AC, 16'h3007, 16'h002A, 0);
    check_val("mwr/pkt_cnt", 64'(pkt_cnt), 64'd2);

    // T3: stray filler entry (len 0, tlast) ahead of a valid TLP
    m_tready = 1'b1;
    push(8'h70, 8'hFF, 1'b1, 12'd0, 8'h00, 0, 1'b0);
    push(8'h80, 8'hFF, 1'b0, 12'd12, 8'h0A, 0, 1'b1);
    push(8'h90, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(0);
    check_frame("drop", 60, 8, 8'h0F, 16'h002E, 16'h0002, 16'h26BB, 16'h300A, 16'h001A, 0);
    check_val("drop/drop_cnt", 64'(drop_cnt), 64'd1);
    check_val("drop/pkt_cnt", 64'(pkt_cnt), 64'd3);

    // T4: FIFO empty for 5 cycles before the third payload beat
    push(8'hA0, 8'hFF, 1'b0, 12'd28, 8'h03, 0, 1'b1);
    push(8'hB0, 8'hFF, 1'b0, 12'd0, 8'h00, 0, 1'b1);
    push(8'hC0, 8'hFF, 1'b0, 12'd0, 8'h00, 5, 1'b1);
    push(8'hD0, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(0);
    check_frame("gap", 76, 10, 8'h0F, 16'h003E, 16'h0003, 16'h26AA, 16'h3003, 16'h002A, 5);
    check_val("gap/err_len_cnt", 64'(err_len_cnt), 64'd0);

    // T5: len says 20 but only 12 bytes arrive before tlast
    push(8'hE0, 8'hFF, 1'b0, 12'd20, 8'h0C, 0, 1'b1);
    push(8'hF0, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(0);
    check_frame("short", 60, 8, 8'h0F, 16'h0036, 16'h0004, 16'h26B1, 16'h300C, 16'h0022, 0);
    check_val("short/err_len_cnt", 64'(err_len_cnt), 64'd1);
    check_val("short/pkt_cnt", 64'(pkt_cnt), 64'd5);

    // T6: reset while header beat 3 is presented
    push(8'h11, 8'hFF, 1'b0, 12'd12, 8'h05, 0, 1'b0);
    push(8'h21, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b0);
    hs = 0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge eth_clk);
      if (m_tvalid && hs == 3) begin
        hit = 1;
        eth_rst = 1'b1;
      end else if (m_tvalid && m_tready) begin
        hs++;
      end
    end
    check_val("rst_mid/reached_beat3", 64'(hit), 64'd1);
    @(negedge eth_clk);
    check_val("rst_mid/tvalid", 64'(m_tvalid), 64'd0);
    check_val("rst_mid/tdata", m_tdata, 64'd0);
    check_val("rst_mid/tkeep", 64'(m_tkeep), 64'd0);
    check_val("rst_mid/tlast", 64'(m_tlast), 64'd0);
    check_val("rst_mid/rd_en", 64'(fifo_rd_en), 64'd0);
    check_val("rst_mid/pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_val("rst_mid/drop_cnt", 64'(drop_cnt), 64'd0);
    check_val("rst_mid/err_len_cnt", 64'(err_len_cnt), 64'd0);
    eth_rst = 1'b0;
    exp_pl.delete();
    repeat (2) @(negedge eth_clk);
    push(8'h12, 8'hFF, 1'b0, 12'd12, 8'h05, 0, 1'b1);
    push(8'h22, 8'h0F, 1'b1, 12'd0, 8'h00, 0, 1'b1);
    run_frame(0);
    check_frame("fresh", 60, 8, 8'h0F, 16'h002E, 16'h0000, 16'h26BD, 16'h3005, 16'h001A, 0);
    check_val("fresh/pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlp_eth_framer.md
Name: tlp_eth_framer

Overview:
- Downstream consumer of the PCIe-RX TLP FIFO. Reads captured TLP beats from a first-word-fall-through FIFO.
- Prepends a 48-byte Ethernet/IPv4/UDP/NetTLP header to each TLP and emits the frame as a 64-bit AXI-stream toward the 10G MAC TX path.
- Sits on the Ethernet side of the FIFO.

Parameters:
UDP_PORT_BASE, 16'h3000, base UDP port; src/dst port = base + tag[3:0]
IP_TTL, 8'd64, IPv4 TTL
MAX_TLP_LEN, 12'd528, largest accepted fifo_len in bytes; larger heads are dropped

Ports:
eth_clk  in  1  sole clock
eth_rst  in  1  synchronous, active-high reset
fifo_tdata  in  64  head-entry TLP data, byte n at bits [8n+7:8n]
fifo_tkeep  in  8  head-entry byte enables
fifo_tlast  in  1  head entry is the last beat of its TLP
fifo_len  in  12  TLP byte length incl. header; nonzero only on the first beat of a TLP
fifo_tag  in  8  TLP tag, valid on the first beat
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  pop head entry (FWFT)
cfg_src_mac, cfg_dst_mac  in  48  MACs, sampled at frame start
cfg_src_ip, cfg_dst_ip  in  32  IPs, sampled at frame start
m_tdata  out  64  frame data, wire byte n of the beat at bits [8n+7:8n]
m_tkeep  out  8  byte enables, contiguous from lane 0
m_tlast  out  1  last beat of frame
m_tvalid  out  1  beat valid
m_tready  in  1  MAC ready
pkt_cnt  out  32  frames sent, wraps
drop_cnt  out  16  entries discarded, saturates at FFFF
err_len_cnt  out  16  TLPs whose byte count is not equal to fifo_len, saturates

Behaviour:
- Reset: m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, fifo_rd_en=0, all counters 0, seq=0, tstamp=0, state=IDLE.
- tstamp: free-running 32-bit counter, +1 per cycle, wraps.
- States: IDLE, DROP, CSUM1, CSUM2, HDR, PAYLOAD.
- IDLE, fifo_empty=1: stay in IDLE.
- IDLE, head fifo_len==0 or fifo_len>MAX_TLP_LEN: go to DROP. This is a resync case, e.g. a mid-TLP beat or the tlast filler beat written after an upstream timeout.
- IDLE, otherwise: latch len, tag, cfg_*, and tstamp; go to CSUM1. No pop in IDLE.
- DROP: fifo_rd_en=1 whenever !fifo_empty; drop_cnt+1 per popped entry. Return to IDLE after popping a tlast entry.
- CSUM1: sum the 10 IPv4 header 16-bit words (checksum word = 0) into a 20-bit accumulator.
  - total_len = 34 + len (12-bit + constant, 16-bit result)
  - id = seq
  - flags/frag = 16'h4000
  - ttl/proto = {IP_TTL, 8'h11}
- CSUM2: fold carries twice, invert, register the checksum; go to HDR.
- HDR: 6 beats, all with m_tkeep=FF. Advance a beat only when m_tvalid&&m_tready. Wire order, multi-byte fields big-endian:
  - dst MAC, src MAC, ethertype 0800
  - IPv4 (45 00 ...)
  - UDP: src = dst = UDP_PORT_BASE+tag[3:0], length = 14+len, checksum 0000
  - NetTLP: seq[15:0], tstamp[31:0]
- PAYLOAD: m_tvalid = !fifo_empty; m_tdata/m_tkeep = fifo head; m_tlast = fifo_tlast; fifo_rd_en = m_tvalid && m_tready.
  - On the tlast handshake: pkt_cnt+1, seq+1; if the accumulated popcount(tkeep) is not equal to len, err_len_cnt+1; go to IDLE.
  - The frame always ends on fifo_tlast; len never truncates or pads the frame.
- AXI rule: once m_tvalid=1, m_tdata/m_tkeep/m_tlast hold stable until the handshake.
- FIFO underrun mid-PAYLOAD drops m_tvalid. The MAC side must tolerate gaps; the FIFO is sized so the upstream fills it at line rate.
- m_tready low during any state: no advance, no pop.
- Back-to-back frames: the next frame can begin 3 cycles after the last beat (IDLE, CSUM1, CSUM2).
- Reset mid-frame: immediate return to reset values. The FIFO shares the reset, so no partial entry survives; DROP covers any that do.
- Minimum-frame padding is the MAC's job.

Test Plan:
- 3DW MRd, fifo_len=12, tag=05, 2 entries -> 8 beats, 60 bytes.
  - Last beat keep=0F.
  - IP total_len=002E, UDP len=001A, ports 3005/3005.
  - Checksum matches a reference model; pkt_cnt=1.
- MWr 3DW with 16 bytes data (len=28), m_tready toggling 1/0 every cycle -> data stable while stalled; 76 bytes; UDP len=002A; seq increments 0→1 across two packets.
- Head entry with fifo_len=0 and tlast=1, followed by a valid TLP -> drop_cnt=1; the valid TLP is framed normally.
- FIFO empties for 5 cycles mid-payload -> m_tvalid low for 5 cycles, no spurious beats, frame completes intact.
- fifo_len=20 but only 12 bytes precede tlast -> frame ends at tlast; err_len_cnt=1.
- eth_rst asserted during HDR beat 3 -> next cycle all outputs 0, state IDLE; a fresh TLP afterwards frames with seq=0.
